// File: rtl/uart_rx_fifo_gen2.sv
// uart_rx_fifo_gen2: receive-side word FIFO between the UART byte-ready strobe and the host read port.
// Latency: push visible in Level/flags at the accepting edge; read data registered at the pop edge
//          (default) or shown combinationally from the head slot (UART_FIFO_FWFT_EN).
// Backpressure: none towards the receiver; a push into a full FIFO is dropped and flagged
//               (FIFO_Overflow), and a pop from an empty FIFO is ignored and flagged (FIFO_Underflow).
//
// Build option: define UART_FIFO_FWFT_EN for first-word fall-through read behaviour.
//
// Ports:
//   clk, rst_n                 clock and asynchronous active-low reset
//   Rx_Data, Data_Rdy          write word and push request
//   Pop_Data                   pop request
//   Flush                      synchronous clear of contents and error flags
//   BIST_Mode                  freeze: every register holds
//   Thresh, Clr_Err            threshold level (0 = off), sticky error clear
//   Data_Out, Data_Valid       read word and its qualifier
//   Level, FIFO_Empty/Full/Thresh  fill status decoded from the registered count
//   FIFO_Overflow/Underflow    sticky error flags
module uart_rx_fifo_gen2 #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_BITS-1:0]  Rx_Data,
  input  logic                  Data_Rdy,
  input  logic                  Pop_Data,
  input  logic                  Flush,
  input  logic                  BIST_Mode,
  input  logic [FIFO_WIDTH:0]   Thresh,
  input  logic                  Clr_Err,
  output logic [DATA_BITS-1:0]  Data_Out,
  output logic                  Data_Valid,
  output logic [FIFO_WIDTH:0]   Level,
  output logic                  FIFO_Empty,
  output logic                  FIFO_Full,
  output logic                  FIFO_Thresh,
  output logic                  FIFO_Overflow,
  output logic                  FIFO_Underflow
);

  localparam int DEPTH = 1 << FIFO_WIDTH;
  localparam logic [FIFO_WIDTH:0] DEPTH_L = (FIFO_WIDTH + 1)'(DEPTH);

  logic [DATA_BITS-1:0]  mem_q [DEPTH];
  logic [FIFO_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_WIDTH:0]   count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic                  mem_we;
  logic                  pop_ok;
  logic                  push_ok;
`ifndef UART_FIFO_FWFT_EN
  logic [DATA_BITS-1:0]  dout_q, dout_d;
  logic                  dvld_q, dvld_d;
`endif

  // Accept decisions use the pre-edge count. A pop on a full FIFO frees the
  // slot the simultaneous push needs, so push_ok depends on pop_ok.
  always_comb begin
    pop_ok  = Pop_Data && (count_q != '0);
    push_ok = Data_Rdy && ((count_q != DEPTH_L) || pop_ok);
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    mem_we   = 1'b0;
`ifndef UART_FIFO_FWFT_EN
    dout_d   = dout_q;
    dvld_d   = dvld_q;
`endif
    if (Flush) begin
      // Memory and the read register are left alone; only bookkeeping clears.
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
`ifndef UART_FIFO_FWFT_EN
      dvld_d   = 1'b0;
`endif
    end else if (!BIST_Mode) begin
      if (push_ok) begin
        mem_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
`ifndef UART_FIFO_FWFT_EN
        dout_d   = mem_q[rd_ptr_q];
`endif
      end
`ifndef UART_FIFO_FWFT_EN
      dvld_d = pop_ok;
`endif
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      // Clear first, then a new error in the same cycle re-sets the flag.
      ovf_d = (ovf_q && !Clr_Err) || (Data_Rdy && !push_ok);
      unf_d = (unf_q && !Clr_Err) || (Pop_Data && !pop_ok);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
`ifndef UART_FIFO_FWFT_EN
      dout_q   <= '0;
      dvld_q   <= 1'b0;
`endif
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
`ifndef UART_FIFO_FWFT_EN
      dout_q   <= dout_d;
      dvld_q   <= dvld_d;
`endif
    end
  end

  // Storage is reset so that the fall-through read port shows 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (mem_we) begin
      mem_q[wr_ptr_q] <= Rx_Data;
    end
  end

  // Status decodes straight from the registered count.
  always_comb begin
    Level          = count_q;
    FIFO_Empty     = (count_q == '0);
    FIFO_Full      = (count_q == DEPTH_L);
    FIFO_Thresh    = (Thresh != '0) && (count_q >= Thresh);
    FIFO_Overflow  = ovf_q;
    FIFO_Underflow = unf_q;
  end

`ifdef UART_FIFO_FWFT_EN
  // Head word is always presented; a pop consumes what is shown.
  always_comb begin
    Data_Out   = mem_q[rd_ptr_q];
    Data_Valid = (count_q != '0);
  end
`else
  always_comb begin
    Data_Out   = dout_q;
    Data_Valid = dvld_q;
  end
`endif

endmodule
